// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM encoding, register offsets and STATUS bit positions
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam logic [31:0] REG_TXDATA = 32'h0000_0000;
  localparam logic [31:0] REG_STATUS = 32'h0000_0004;
  localparam logic [31:0] REG_CTRL   = 32'h0000_0008;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;

  function automatic logic [29:0] word_of(input logic [31:0] byte_addr);
    return byte_addr[31:2];
  endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// rtl/mmio_uart_tx_if.sv - control bundle between the UART engine and its TX FIFO
interface mmio_uart_tx_if #(
  parameter int DEPTH = 8,
  parameter int W     = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          push;
  logic          pop;
  logic          flush;
  logic [W-1:0]  wdata;
  logic [W-1:0]  rdata;
  logic          full;
  logic          empty;
  logic          drop;
  logic [CW-1:0] count;

  modport master (output push, pop, flush, wdata, input rdata, full, empty, drop, count);
  modport slave  (input push, pop, flush, wdata, output rdata, full, empty, drop, count);
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - power-of-two synchronous FIFO with flush and drop-on-full
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input logic           clk,
  input logic           resetn,
  mmio_uart_tx_if.slave f
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign f.full  = (cnt == CW'(DEPTH));
  assign f.empty = (cnt == '0);
  assign f.count = cnt;
  assign f.rdata = mem[rd_ptr];

  // A pop in the same cycle frees the slot, so a push at full is still accepted.
  assign do_pop  = f.pop && !f.empty;
  assign do_push = f.push && (!f.full || do_pop);
  assign f.drop  = f.push && f.full && !do_pop;

  always_ff @(posedge clk) begin
    if (do_push && !f.flush) mem[wr_ptr] <= f.wdata;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (f.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with TX FIFO
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Hit,
  output logic        TxD
);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  mmio_uart_tx_if #(.DEPTH(FIFO_DEPTH), .W(8)) fq ();

  sync_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk    (CLK),
    .resetn (Reset),
    .f      (fq.slave)
  );

  tx_state_e     state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shift, shift_n;
  logic          txd_n;
  logic          pop;
  logic          overflow;
  logic          baud_last;
  logic [29:0]   word_off;
  logic          sel_txdata, sel_status, sel_ctrl;
  logic          ovf_clr;
  logic [31:0]   status;
  logic          unused_bits;

  // Offset is taken modulo 2^30 so addresses below the base never alias into the window.
  assign word_off   = Addr[31:2] - BASE_ADDR[31:2];
  assign sel_txdata = (word_off == word_of(REG_TXDATA));
  assign sel_status = (word_off == word_of(REG_STATUS));
  assign sel_ctrl   = (word_off == word_of(REG_CTRL));
  assign Hit        = sel_txdata || sel_status || sel_ctrl;
  assign ReadData   = sel_status ? status : 32'h0;
  assign unused_bits = ^{Addr[1:0], WriteData[31:8]};

  assign fq.push  = MemWrite && sel_txdata;
  assign fq.wdata = WriteData[7:0];
  assign fq.flush = MemWrite && sel_ctrl && WriteData[0];
  assign fq.pop   = pop;
  assign ovf_clr  = MemWrite && sel_ctrl && WriteData[1];

  always_comb begin
    status                          = 32'h0;
    status[STAT_FULL]               = fq.full;
    status[STAT_EMPTY]              = fq.empty;
    status[STAT_BUSY]               = (state != ST_IDLE);
    status[STAT_OVF]                = overflow;
    status[STAT_CNT_LSB +: 4]       = 4'(fq.count);
  end

  assign baud_last = (baud == BAUD_LAST);

  always_comb begin
    state_n = state;
    baud_n  = baud_last ? '0 : baud + 1'b1;
    bit_n   = bit_idx;
    shift_n = shift;
    txd_n   = TxD;
    pop     = 1'b0;
    case (state)
      ST_IDLE: begin
        baud_n = '0;
        txd_n  = 1'b1;
        if (!fq.empty) begin
          pop     = 1'b1;
          shift_n = fq.rdata;
          state_n = ST_START;
          txd_n   = 1'b0;
        end
      end
      ST_START: begin
        if (baud_last) begin
          state_n = ST_DATA;
          txd_n   = shift[0];
          shift_n = {1'b0, shift[7:1]};
          bit_n   = 3'd0;
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          if (bit_idx == 3'd7) begin
            state_n = ST_STOP;
            txd_n   = 1'b1;
          end else begin
            txd_n   = shift[0];
            shift_n = {1'b0, shift[7:1]};
            bit_n   = bit_idx + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          if (!fq.empty) begin
            pop     = 1'b1;
            shift_n = fq.rdata;
            state_n = ST_START;
            txd_n   = 1'b0;
          end else begin
            state_n = ST_IDLE;
            txd_n   = 1'b1;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        baud_n  = '0;
        txd_n   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state    <= ST_IDLE;
      baud     <= '0;
      bit_idx  <= 3'd0;
      shift    <= 8'h00;
      TxD      <= 1'b1;
      overflow <= 1'b0;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
      TxD     <= txd_n;
      // A drop in the same cycle as a clear keeps the flag set.
      if (fq.drop)     overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end
endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 The block SHALL declare parameter BASE_ADDR, default 32'hFFFF_0000, the word-aligned base of its 3-word register window.
REQ-002 The block SHALL declare parameter CLKS_PER_BIT, default 868, the number of CLK cycles per serial bit.
REQ-003 The block SHALL declare parameter FIFO_DEPTH, default 8 (power of two), the TX FIFO entries.
REQ-004 The block SHALL have port CLK, input, 1 bit: single clock, all state updates on its rising edge.
REQ-005 The block SHALL have port Reset, input, 1 bit: reset, synchronous and active-low (Reset=0 resets at the next rising CLK edge).
REQ-006 The block SHALL have port MemWrite, input, 1 bit: store strobe from the core M stage.
REQ-007 The block SHALL have port Addr, input, 32 bits: byte address from the core M stage (the OpResult bus).
REQ-008 The block SHALL have port WriteData, input, 32 bits: store data from the core M stage.
REQ-009 The block SHALL have port ReadData, output, 32 bits: combinational register read data, 0 when Hit=0.
REQ-010 The block SHALL have port Hit, output, 1 bit: combinational, high when Addr[31:2] selects a register in the window; the top level uses it to mux ReadData over data RAM and to suppress the RAM write.
REQ-011 The block SHALL have port TxD, output, 1 bit: registered serial line, idle high.

Function
REQ-012 Register map SHALL be: +0 TXDATA (W: push WriteData[7:0]; R: 0); +4 STATUS (R only); +8 CTRL (W: bit0 flush FIFO, bit1 clear overflow; R: 0). Addr[1:0] SHALL be ignored.
REQ-013 STATUS SHALL read {24'b0, count[3:0], overflow, busy, empty, full}, with full at bit0, empty bit1, busy bit2, overflow bit3 and count at bits[7:4].
REQ-014 A push SHALL occur on a rising edge where MemWrite=1 and the address hits TXDATA; if the FIFO is full and no pop occurs that cycle, the byte SHALL be dropped and overflow SHALL be set (sticky).
REQ-015 A simultaneous push and pop SHALL leave count unchanged; a push at full with a simultaneous pop SHALL be accepted.
REQ-016 The FIFO SHALL wrap its read and write pointers modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH.
REQ-017 The FSM SHALL have states IDLE, START, DATA and STOP, each bit held for exactly CLKS_PER_BIT cycles, timed by a baud counter running 0..CLKS_PER_BIT-1.
REQ-018 IDLE with FIFO non-empty SHALL pop and load the shift register at the next edge, enter START and drive TxD=0; with CLKS_PER_BIT=N, TxD SHALL fall N… the edge after the push edge (2 edges after the write cycle begins, when idle and empty).
REQ-019 DATA SHALL send 8 bits LSB first; STOP SHALL drive TxD=1 for one bit; the frame SHALL be 10*CLKS_PER_BIT cycles.
REQ-020 At the end of STOP, a non-empty FIFO SHALL pop and enter START directly, with no idle gap; otherwise the FSM SHALL return to IDLE.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 A CTRL flush SHALL empty the FIFO at that edge; a frame already in progress SHALL complete unchanged; a flush coincident with a pop SHALL still result in count=0.
REQ-023 A CTRL bit1 write SHALL clear overflow; if an overflow event occurs in the same cycle, set SHALL win (not possible through a single address, but required).
REQ-024 A write to an unmapped address, or to STATUS, SHALL have no effect.

Reset
REQ-025 On reset the block SHALL set state=IDLE, TxD=1, FIFO pointers and count to 0, overflow=0, the baud counter to 0 and the shift register to 0; STATUS SHALL then read 32'h0000_0002.
REQ-026 Reset asserted mid-frame SHALL abort the frame, with TxD=1 from the next edge.

Structure
REQ-027 Shared package uart_pkg SHALL hold the FSM state encoding, the register offsets (TXDATA=0, STATUS=4, CTRL=8) and the STATUS bit positions.
REQ-028 The FIFO SHALL be a sub-module named sync_fifo (push, pop, flush, full, empty, count); the FSM, baud counter and decode SHALL stay in mmio_uart_tx.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=8)
REQ-029 Store 0x55 to TXDATA while idle -> TxD low 4 cycles from edge 2, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high; frame 40 cycles; busy=1 throughout.
REQ-030 10 consecutive TXDATA stores (0x00..0x09) from idle -> bytes 0..8 accepted; STATUS = count 8, full=1, overflow=1; the line then sends 0x00..0x08 back-to-back over 360 cycles with no gap.
REQ-031 Reset=0 at cycle 15 of a frame -> TxD=1 the next cycle; STATUS=0x02; no further frames.
REQ-032 Push 3 bytes, then CTRL=0x1 during the first frame -> the first frame completes; bytes 2 and 3 are never sent; STATUS=0x02 after the stop bit.
REQ-033 Read BASE+4 -> Hit=1 with STATUS value; read BASE+12 -> Hit=0 and ReadData=0; store to BASE+12 -> count unchanged.
